line_raster_engine: RTL and testbench

//  Parametrised successor to the single-colour line drawer. Rasterises one primitive per command:

---
 rtl/line_raster_pkg.sv | 12 +
 rtl/bresenham_step.sv | 39 +++
 rtl/line_raster_engine.sv | 154 +++++++++++++++
 tb/tb_line_raster_engine.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/line_raster_pkg.sv
// Shared types and helpers for the line/rectangle rasteriser.
package line_raster_pkg;

  typedef enum logic {MODE_LINE, MODE_RECT} raster_mode_t;

  typedef enum logic [2:0] {IDLE, SETUP, LINE_DRAW, RECT_FILL, FINISH} raster_state_t;

  function automatic int unsigned abs_diff(input int unsigned a, input int unsigned b);
    return (a > b) ? a - b : b - a;
  endfunction

endpackage

// File: rtl/bresenham_step.sv
// One combinational Bresenham step: next point and next error term.
module bresenham_step #(
  parameter int unsigned COORD_W = 11
) (
  input  logic        [COORD_W-1:0] x,
  input  logic        [COORD_W-1:0] y,
  input  logic signed [COORD_W+1:0] err,
  input  logic signed [COORD_W+1:0] dx,
  input  logic signed [COORD_W+1:0] dy,
  input  logic signed [1:0]         sx,
  input  logic signed [1:0]         sy,
  output logic        [COORD_W-1:0] x_next,
  output logic        [COORD_W-1:0] y_next,
  output logic signed [COORD_W+1:0] err_next
);

  // One extra bit so 2*err cannot overflow.
  logic signed [COORD_W+2:0] e2;
  logic signed [COORD_W+2:0] dx_w;
  logic signed [COORD_W+2:0] dy_w;

  always_comb begin
    e2       = {err, 1'b0};
    dx_w     = {dx[COORD_W+1], dx};
    dy_w     = {dy[COORD_W+1], dy};
    x_next   = x;
    y_next   = y;
    err_next = err;
    if (e2 >= dy_w) begin
      err_next = err_next + dy;
      x_next   = x + {{(COORD_W-2){sx[1]}}, sx};
    end
    if (e2 <= dx_w) begin
      err_next = err_next + dx;
      y_next   = y + {{(COORD_W-2){sy[1]}}, sy};
    end
  end

endmodule

// File: rtl/line_raster_engine.sv
// Rasterises one Bresenham line or filled rectangle per command onto a
// valid/ready pixel stream, silently skipping off-screen points.
module line_raster_engine
  import line_raster_pkg::*;
#(
  parameter int unsigned COORD_W = 11,
  parameter int unsigned COLOR_W = 1,
  parameter int unsigned X_MAX   = 639,
  parameter int unsigned Y_MAX   = 479
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               mode,
  input  logic [COORD_W-1:0] x0,
  input  logic [COORD_W-1:0] y0,
  input  logic [COORD_W-1:0] x1,
  input  logic [COORD_W-1:0] y1,
  input  logic [COLOR_W-1:0] color_in,
  input  logic               pix_ready,
  output logic               busy,
  output logic               done,
  output logic               pix_valid,
  output logic               pix_write,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic [COLOR_W-1:0] pix_color
);

  localparam int unsigned EW = COORD_W + 2;

  raster_state_t state;
  raster_mode_t  mode_q;

  logic [COORD_W-1:0] x0_q, y0_q, x1_q, y1_q;
  logic [COORD_W-1:0] x_min, x_lim, y_lim;
  logic [COORD_W-1:0] x_lo, x_hi, y_lo, y_hi;
  logic signed [EW-1:0] err, dx, dy, adx, ady;
  logic signed [1:0]    sx, sy;

  logic [COORD_W-1:0]   x_next, y_next;
  logic signed [EW-1:0] err_next;

  logic drawing, visible, advance, last_point;

  assign adx  = EW'(abs_diff(32'(x1_q), 32'(x0_q)));
  assign ady  = EW'(abs_diff(32'(y1_q), 32'(y0_q)));
  assign x_lo = (x0_q < x1_q) ? x0_q : x1_q;
  assign x_hi = (x0_q < x1_q) ? x1_q : x0_q;
  assign y_lo = (y0_q < y1_q) ? y0_q : y1_q;
  assign y_hi = (y0_q < y1_q) ? y1_q : y0_q;

  bresenham_step #(.COORD_W(COORD_W)) u_step (
    .x        (x),
    .y        (y),
    .err      (err),
    .dx       (dx),
    .dy       (dy),
    .sx       (sx),
    .sy       (sy),
    .x_next   (x_next),
    .y_next   (y_next),
    .err_next (err_next)
  );

  // Clipped points advance on their own; visible ones wait for the handshake.
  assign drawing    = (state == LINE_DRAW) || (state == RECT_FILL);
  assign visible    = (32'(x) <= X_MAX) && (32'(y) <= Y_MAX);
  assign pix_valid  = drawing && visible;
  assign pix_write  = pix_valid && pix_ready;
  assign advance    = pix_write || !visible;
  assign last_point = (mode_q == MODE_LINE) ? ((x == x1_q) && (y == y1_q))
                                            : ((x == x_lim) && (y == y_lim));

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      mode_q    <= MODE_LINE;
      busy      <= 1'b0;
      done      <= 1'b0;
      x         <= '0;
      y         <= '0;
      pix_color <= '0;
      x0_q      <= '0;
      y0_q      <= '0;
      x1_q      <= '0;
      y1_q      <= '0;
      x_min     <= '0;
      x_lim     <= '0;
      y_lim     <= '0;
      err       <= '0;
      dx        <= '0;
      dy        <= '0;
      sx        <= '0;
      sy        <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            x0_q      <= x0;
            y0_q      <= y0;
            x1_q      <= x1;
            y1_q      <= y1;
            mode_q    <= raster_mode_t'(mode);
            pix_color <= color_in;
            busy      <= 1'b1;
            state     <= SETUP;
          end
        end
        SETUP: begin
          if (mode_q == MODE_LINE) begin
            dx    <= adx;
            dy    <= -ady;
            err   <= adx - ady;
            sx    <= (x1_q >= x0_q) ? 2'sb01 : 2'sb11;
            sy    <= (y1_q >= y0_q) ? 2'sb01 : 2'sb11;
            x     <= x0_q;
            y     <= y0_q;
            state <= LINE_DRAW;
          end else begin
            x     <= x_lo;
            y     <= y_lo;
            x_min <= x_lo;
            x_lim <= x_hi;
            y_lim <= y_hi;
            state <= RECT_FILL;
          end
        end
        LINE_DRAW, RECT_FILL: begin
          if (advance) begin
            if (last_point) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= FINISH;
            end else if (state == LINE_DRAW) begin
              x   <= x_next;
              y   <= y_next;
              err <= err_next;
            end else if (x == x_lim) begin
              x <= x_min;
              y <= y + 1'b1;
            end else begin
              x <= x + 1'b1;
            end
          end
        end
        FINISH:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_line_raster_engine.sv
// Checks line_raster_engine against a point-list model built from the drawing rules.
module tb_line_raster_engine;

  localparam int unsigned COORD_W = 11;
  localparam int unsigned COLOR_W = 1;
  localparam int unsigned X_MAX   = 639;
  localparam int unsigned Y_MAX   = 479;

  logic               clk = 1'b0;
  logic               reset, start, mode, pix_ready;
  logic [COORD_W-1:0] x0, y0, x1, y1, x, y;
  logic [COLOR_W-1:0] color_in, pix_color;
  logic               busy, done, pix_valid, pix_write;

  int n_checks = 0;
  int n_errors = 0;
  int exp_x[$];
  int exp_y[$];
  int n_points;
  bit first_vis;

  always #5 clk = ~clk;

  line_raster_engine #(
    .COORD_W (COORD_W),
    .COLOR_W (COLOR_W),
    .X_MAX   (X_MAX),
    .Y_MAX   (Y_MAX)
  ) u_dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .mode      (mode),
    .x0        (x0),
    .y0        (y0),
    .x1        (x1),
    .y1        (y1),
    .color_in  (color_in),
    .pix_ready (pix_ready),
    .busy      (busy),
    .done      (done),
    .pix_valid (pix_valid),
    .pix_write (pix_write),
    .x         (x),
    .y         (y),
    .pix_color (pix_color)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Full point sequence of the primitive; only on-screen points are queued.
  function automatic void build_expected(input bit m, input int ax, input int ay,
                                         input int bx, input int by);
    int px, py, pts[$][2];
    exp_x.delete();
    exp_y.delete();
    if (!m) begin
      int dx, dy, sx, sy, err, e2;
      dx = iabs(bx - ax); dy = -iabs(by - ay);
      sx = (bx >= ax) ? 1 : -1; sy = (by >= ay) ? 1 : -1;
      err = dx + dy; px = ax; py = ay;
      forever begin
        pts.push_back('{px, py});
        if (px == bx && py == by) break;
        e2 = 2 * err;
        if (e2 >= dy) begin err += dy; px += sx; end
        if (e2 <= dx) begin err += dx; py += sy; end
      end
    end else begin
      for (int yy = (ay < by ? ay : by); yy <= (ay < by ? by : ay); yy++)
        for (int xx = (ax < bx ? ax : bx); xx <= (ax < bx ? bx : ax); xx++)
          pts.push_back('{xx, yy});
    end
    n_points  = pts.size();
    first_vis = (pts[0][0] <= int'(X_MAX)) && (pts[0][1] <= int'(Y_MAX));
    foreach (pts[i])
      if (pts[i][0] <= int'(X_MAX) && pts[i][1] <= int'(Y_MAX)) begin
        exp_x.push_back(pts[i][0]);
        exp_y.push_back(pts[i][1]);
      end
  endfunction

  // rmode: 0 = always ready, 1 = toggle 1,0,1,0..., 2 = random
  task automatic run_prim(input string name, input bit m, input int ax, input int ay,
                          input int bx, input int by, input int rmode, input bit hold_start);
    int iter, idx, bound, px, py;
    bit prev_stall, got_done;
    logic [COLOR_W-1:0] col;
    build_expected(m, ax, ay, bx, by);
    col = COLOR_W'($urandom);
    @(negedge clk);
    mode = m; x0 = COORD_W'(ax); y0 = COORD_W'(ay); x1 = COORD_W'(bx); y1 = COORD_W'(by);
    color_in = col; start = 1'b1; pix_ready = 1'b0;
    @(negedge clk);
    #1;
    if (!hold_start) start = 1'b0;
    check({name, " busy_setup"}, 32'(busy), 1);
    check({name, " valid_setup"}, 32'(pix_valid), 0);
    iter = 0; idx = 0; prev_stall = 0; got_done = 0; px = 0; py = 0;
    bound = 4 * n_points + 20;
    while (!got_done && iter < bound) begin
      @(negedge clk);
      case (rmode)
        0:       pix_ready = 1'b1;
        1:       pix_ready = (iter % 2 == 0);
        default: pix_ready = 1'($urandom_range(0, 1));
      endcase
      #1;
      iter++;
      if (iter == 1) check({name, " first_valid"}, 32'(pix_valid), 32'(first_vis));
      if (prev_stall) begin
        check({name, " hold_x"}, 32'(x), px);
        check({name, " hold_y"}, 32'(y), py);
      end
      check({name, " write_eq"}, 32'(pix_write), 32'(pix_valid & pix_ready));
      if (done) begin
        got_done = 1;
        check({name, " busy_done"}, 32'(busy), 0);
        start = 1'b0;
      end else begin
        check({name, " busy_draw"}, 32'(busy), 1);
        if (pix_write) begin
          if (idx < exp_x.size()) begin
            check({name, " x"}, 32'(x), exp_x[idx]);
            check({name, " y"}, 32'(y), exp_y[idx]);
            check({name, " color"}, 32'(pix_color), 32'(col));
          end else begin
            check({name, " extra_write"}, idx, exp_x.size());
          end
          idx++;
        end
      end
      prev_stall = pix_valid && !pix_ready;
      px = int'(x); py = int'(y);
    end
    start = 1'b0;
    check({name, " done_seen"}, 32'(got_done), 1);
    check({name, " write_count"}, idx, exp_x.size());
    if (rmode == 0 && got_done) check({name, " cycles"}, iter, n_points + 1);
    @(negedge clk);
    #1;
    check({name, " done_pulse"}, 32'(done), 0);
    check({name, " busy_idle"}, 32'(busy), 0);
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, " busy"}, 32'(busy), 0);
    check({name, " done"}, 32'(done), 0);
    check({name, " pix_valid"}, 32'(pix_valid), 0);
    check({name, " pix_write"}, 32'(pix_write), 0);
    check({name, " x"}, 32'(x), 0);
    check({name, " y"}, 32'(y), 0);
    check({name, " pix_color"}, 32'(pix_color), 0);
  endtask

  initial begin
    int cnt, ax, ay, bx, by;
    bit saw_done, m;
    reset = 1'b1; start = 1'b0; mode = 1'b0; pix_ready = 1'b0;
    x0 = '0; y0 = '0; x1 = '0; y1 = '0; color_in = '0;
    repeat (3) @(negedge clk);
    #1;
    check_outputs_zero("reset");
    reset = 1'b0;

    run_prim("line_h",     1'b0, 0, 0, 10, 0, 0, 1'b0);
    run_prim("line_diag",  1'b0, 10, 10, 0, 0, 0, 1'b0);
    run_prim("line_steep", 1'b0, 0, 0, 3, 10, 0, 1'b0);
    run_prim("line_dot",   1'b0, 5, 7, 5, 7, 0, 1'b0);
    run_prim("line_bp",    1'b0, 0, 0, 4, 4, 1, 1'b0);
    run_prim("rect",       1'b1, 4, 4, 2, 3, 0, 1'b0);
    run_prim("clip",       1'b0, 636, 0, 643, 0, 0, 1'b1);
    run_prim("rect_clip",  1'b1, 637, 477, 641, 481, 2, 1'b0);

    // Abort a long line with reset partway through.
    @(negedge clk);
    mode = 1'b0; x0 = '0; y0 = '0; x1 = COORD_W'(100); y1 = '0;
    color_in = '1; start = 1'b1; pix_ready = 1'b1;
    @(negedge clk);
    #1;
    start = 1'b0;
    cnt = 0;
    for (int i = 0; i < 200 && cnt < 20; i++) begin
      @(negedge clk);
      #1;
      if (pix_write) cnt++;
    end
    check("abort progress", cnt, 20);
    reset = 1'b1;
    @(negedge clk);
    #1;
    check_outputs_zero("abort");
    reset = 1'b0;
    saw_done = 0;
    repeat (6) begin
      @(negedge clk);
      #1;
      if (done || busy) saw_done = 1;
    end
    check("abort no_done", 32'(saw_done), 0);
    run_prim("after_abort", 1'b0, 2, 9, 7, 3, 2, 1'b0);

    for (int t = 0; t < 24; t++) begin
      m  = 1'($urandom_range(0, 1));
      ax = $urandom_range(0, 700);
      ay = $urandom_range(0, 520);
      if (!m) begin
        bx = ax + $urandom_range(0, 60) - 30;
        by = ay + $urandom_range(0, 60) - 30;
      end else begin
        bx = ax + $urandom_range(0, 14) - 7;
        by = ay + $urandom_range(0, 14) - 7;
      end
      if (bx < 0) bx = 0;
      if (by < 0) by = 0;
      run_prim($sformatf("rand%0d", t), m, ax, ay, bx, by, 2, 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
